// File: rtl/stream_merge_rr.sv
// Round-robin N-to-1 stream merger with stb/ack handshake and sticky exception aggregation.
// Optional send watchdog enabled by defining STREAM_MERGE_RR_TIMEOUT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no word held; pick next requester by rotating priority
// S_ACCEPT | in_ack[g] high this cycle; capture in_data[g]
// S_SEND   | out_stb high, word held stable until out_ack (or watchdog)

module stream_merge_rr #(
   parameter int N       = 4,
   parameter int WIDTH   = 32,
   parameter int CW      = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_stb,
   output logic [N-1:0]       in_ack,
   output logic [WIDTH-1:0]   out_data,
   output logic [CW-1:0]      out_chan,
   output logic               out_stb,
   input  logic               out_ack,
   input  logic [N-1:0]       exc_in,
   output logic               exception,
   output logic [N-1:0]       exc_src
);

   localparam int  CW_MIN = (N > 1) ? $clog2(N) : 1;
   localparam bit  CFG_OK = (N >= 1) && (N <= 16) && (CW == CW_MIN) && (TIMEOUT >= 2);

   if (!CFG_OK) begin : g_bad_cfg
      $error("stream_merge_rr: illegal N/CW/TIMEOUT combination");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCEPT = 2'd1,
      S_SEND   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [CW-1:0]     r_grant;
   logic [CW-1:0]     r_last_grant;
   logic [N-1:0]      r_in_ack;
   logic [WIDTH-1:0]  r_out_data;
   logic [CW-1:0]     r_out_chan;
   logic              r_out_stb;
   logic [N-1:0]      r_exc_src;
   logic              r_exception;

   logic              w_req_any;
   logic [CW-1:0]     w_sel;
   logic [N-1:0]      w_ack_nxt;
   logic [WIDTH-1:0]  w_data_sel;
   logic              w_send_end;
   logic              w_timeout;
   logic              w_to_flag;

`ifdef STREAM_MERGE_RR_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [TW-1:0]     r_to_cnt;
   logic              r_to_flag;

   assign w_to_flag = r_to_flag;
`else
   assign w_to_flag = 1'b0;
`endif

   // Scan from farthest to nearest so the nearest requester after last_grant wins.
   always_comb begin
      int idx;
      idx       = 0;
      w_sel     = r_last_grant;
      w_req_any = 1'b0;
      for (int k = N; k >= 1; k--) begin
         idx = (int'(r_last_grant) + k) % N;
         if (in_stb[idx]) begin
            w_sel     = CW'(idx);
            w_req_any = 1'b1;
         end
      end
   end

   always_comb begin
      w_ack_nxt = '0;
      for (int i = 0; i < N; i++) begin
         w_ack_nxt[i] = w_req_any && (w_sel == CW'(i));
      end
   end

   always_comb begin
      w_data_sel = in_data[int'(r_grant)*WIDTH +: WIDTH];
   end

   always_comb begin
      w_state_nxt = r_state;
      w_send_end  = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req_any) begin
               w_state_nxt = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            w_state_nxt = S_SEND;
         end
         S_SEND: begin
            if (out_ack) begin
               w_state_nxt = S_IDLE;
               w_send_end  = 1'b1;
            end
`ifdef STREAM_MERGE_RR_TIMEOUT_EN
            else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
               w_state_nxt = S_IDLE;
               w_send_end  = 1'b1;
               w_timeout   = 1'b1;
            end
`endif
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_grant      <= '0;
         r_last_grant <= CW'(N - 1);
         r_in_ack     <= '0;
         r_out_data   <= '0;
         r_out_chan   <= '0;
         r_out_stb    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_in_ack <= w_ack_nxt;
               if (w_req_any) begin
                  r_grant <= w_sel;
               end
            end
            S_ACCEPT: begin
               r_in_ack   <= '0;
               r_out_data <= w_data_sel;
               r_out_chan <= r_grant;
               r_out_stb  <= 1'b1;
            end
            S_SEND: begin
               if (w_send_end) begin
                  r_out_stb    <= 1'b0;
                  r_last_grant <= r_grant;
               end
            end
            default: begin
               r_in_ack  <= '0;
               r_out_stb <= 1'b0;
            end
         endcase
      end
   end

`ifdef STREAM_MERGE_RR_TIMEOUT_EN
   // Expiry and out_ack in the same cycle resolve as a normal transfer (ack is checked first).
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_to_cnt  <= '0;
         r_to_flag <= 1'b0;
      end else begin
         if (r_state == S_ACCEPT) begin
            r_to_cnt <= '0;
         end else if (r_state == S_SEND && !w_send_end) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
         if (w_timeout) begin
            r_to_flag <= 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_exc_src   <= '0;
         r_exception <= 1'b0;
      end else begin
         r_exc_src   <= r_exc_src | exc_in;
         r_exception <= (|r_exc_src) | w_to_flag;
      end
   end

   assign in_ack    = r_in_ack;
   assign out_data  = r_out_data;
   assign out_chan  = r_out_chan;
   assign out_stb   = r_out_stb;
   assign exc_src   = r_exc_src;
   assign exception = r_exception;

endmodule

// File: tb/tb_stream_merge_rr.sv
// Scoreboard bench for stream_merge_rr: random sources, rotating-priority reference model,
// decoupled output monitor. Watchdog checks compile in with STREAM_MERGE_RR_TIMEOUT_EN.

module tb_stream_merge_rr;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int CW = 2;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_stb = '1;
   logic [N-1:0]    in_ack;
   logic [W-1:0]    out_data;
   logic [CW-1:0]   out_chan;
   logic            out_stb;
   logic            out_ack = 1'b0;
   logic [N-1:0]    exc_in = '0;
   logic            exception;
   logic [N-1:0]    exc_src;

   always #5 clk = ~clk;

   stream_merge_rr #(.N(N), .WIDTH(W), .CW(CW), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_stb    (in_stb),
      .in_ack    (in_ack),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_stb   (out_stb),
      .out_ack   (out_ack),
      .exc_in    (exc_in),
      .exception (exception),
      .exc_src   (exc_src)
   );

   logic [W-1:0] src_data [N] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};

   for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign in_data[gi*W +: W] = src_data[gi];
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   // Stimulus controls
   bit           drv_en    = 1'b0;
   logic [N-1:0] en_mask   = '0;
   bit           rnd_stb   = 1'b0;
   int           ack_mode  = 1;
   bit           use_fixed = 1'b0;
   logic [W-1:0] fixed_val = '0;
   bit           gap_chk   = 1'b0;

   logic [N-1:0] hs_seen = '0;

   // Sources: hold data+stb until acked; may withdraw only while not granted.
   always @(posedge clk) begin
      #1;
      if (drv_en) begin
         for (int i = 0; i < N; i++) begin
            bit w;
            w = en_mask[i] && (!rnd_stb || ($urandom_range(0, 3) != 0));
            if (hs_seen[i]) begin
               in_stb[i] = w;
               if (w) src_data[i] = use_fixed ? fixed_val : $urandom();
            end else if (!in_ack[i]) begin
               if (in_stb[i] && !w) begin
                  in_stb[i] = 1'b0;
               end else if (!in_stb[i] && w) begin
                  in_stb[i]   = 1'b1;
                  src_data[i] = use_fixed ? fixed_val : $urandom();
               end
            end
         end
         case (ack_mode)
            0:       out_ack = 1'b0;
            1:       out_ack = 1'b1;
            default: out_ack = ($urandom_range(0, 9) < 7);
         endcase
      end
   end

   // Reference model + monitor
   logic [CW+W-1:0] q[$];
   int              m_last   = N - 1;
   logic [N-1:0]    prev_stb = '0;
   logic [N-1:0]    prev_ack = '0;
   logic            prev_ostb = 1'b0;
   logic            prev_oack = 1'b0;
   logic [W-1:0]    hold_data;
   logic [CW-1:0]   hold_chan;
   int              send_cyc = 0;
   longint          cyc = 0;
   longint          last_hs = -1;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         q.delete();
         m_last    = N - 1;
         prev_ack  = '0;
         prev_ostb = 1'b0;
         prev_oack = 1'b0;
         send_cyc  = 0;
         hs_seen   = '0;
         prev_stb  = in_stb;
      end else begin
         hs_seen = in_stb & in_ack;

         if (in_ack != '0) begin
            int  exp_ch;
            bit  found;
            exp_ch = 0;
            found  = 1'b0;
            for (int k = 1; k <= N; k++) begin
               if (!found && prev_stb[(m_last + k) % N]) begin
                  exp_ch = (m_last + k) % N;
                  found  = 1'b1;
               end
            end
            if (!found) begin
               chk("spurious_grant", in_ack, 0);
            end else begin
               chk("grant", in_ack, 64'(1) << exp_ch);
               m_last = exp_ch;
               q.push_back({CW'(exp_ch), src_data[exp_ch]});
            end
         end

         if (prev_ack != '0) begin
            chk("lat_out_stb", out_stb, 1);
            chk("ack_one_cycle", in_ack, 0);
         end
         if (out_stb && in_ack != '0) chk("ack_during_send", in_ack, 0);

         if (prev_ostb && prev_oack) chk("stb_after_xfer", out_stb, 0);

         if (prev_ostb && !prev_oack) begin
`ifdef STREAM_MERGE_RR_TIMEOUT_EN
            if (!out_stb) begin
               chk("drop_len", send_cyc, TO);
               if (q.size() == 0) chk("drop_sb_empty", q.size(), 1);
               else void'(q.pop_front());
            end
`else
            chk("stall_hold", out_stb, 1);
`endif
            if (out_stb) begin
               chk("stall_data", out_data, hold_data);
               chk("stall_chan", out_chan, hold_chan);
            end
         end

         if (out_stb && out_ack) begin
            if (q.size() == 0) begin
               chk("sb_underflow", q.size(), 1);
            end else begin
               logic [CW+W-1:0] e;
               e = q.pop_front();
               chk("out_data", out_data, e[W-1:0]);
               chk("out_chan", out_chan, e[CW+W-1:W]);
            end
            if (gap_chk && last_hs >= 0) chk("rr_gap", cyc - last_hs, 3);
            last_hs = gap_chk ? cyc : -1;
         end
         if (!gap_chk) last_hs = -1;

         send_cyc  = out_stb ? (prev_ostb ? send_cyc + 1 : 1) : 0;
         hold_data = out_data;
         hold_chan = out_chan;
         prev_ostb = out_stb;
         prev_oack = out_ack;
         prev_ack  = in_ack;
         prev_stb  = in_stb;
      end
   end

   task automatic drain();
      int n;
      en_mask  = '0;
      ack_mode = 1;
      gap_chk  = 1'b0;
      n = 0;
      while ((q.size() != 0 || out_stb || in_ack != '0 || in_stb != '0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_done", (n < 300), 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      // Reset held with every strobe high
      repeat (3) begin
         @(negedge clk);
         chk("rst_in_ack", in_ack, 0);
         chk("rst_out_stb", out_stb, 0);
         chk("rst_exception", exception, 0);
         chk("rst_exc_src", exc_src, 0);
      end

      // Round robin, all channels busy, sink always ready: chan 0 first, one word per 3 cycles
      @(posedge clk); #1;
      rst      = 1'b1;
      en_mask  = '1;
      rnd_stb  = 1'b0;
      ack_mode = 1;
      gap_chk  = 1'b1;
      drv_en   = 1'b1;
      repeat (40) @(posedge clk);
      drain();

      // Single word on channel 2
      use_fixed = 1'b1;
      fixed_val = 32'hDEAD_BEEF;
      en_mask   = 4'b0100;
      repeat (6) @(posedge clk);
      drain();
      use_fixed = 1'b0;

      // Backpressure: sink stalls 20 cycles
      en_mask  = '1;
      ack_mode = 0;
      repeat (20) @(posedge clk);
      ack_mode = 1;
      repeat (20) @(posedge clk);
      drain();

      // Random traffic with random sink readiness
      en_mask  = '1;
      rnd_stb  = 1'b1;
      ack_mode = 2;
      repeat (3000) @(posedge clk);
      rnd_stb = 1'b0;
      drain();

      // Exceptions: one-cycle pulse on exc_in[3]
      do_reset();
      @(negedge clk);
      chk("exc_clr_src", exc_src, 0);
      chk("exc_clr_out", exception, 0);
      @(posedge clk); #1;
      exc_in = 4'b1000;
      @(posedge clk); #1;
      exc_in = 4'b0000;
      @(negedge clk);
      chk("exc_src_set", exc_src, 4'b1000);
      chk("exc_not_yet", exception, 0);
      @(negedge clk);
      chk("exc_out_set", exception, 1);
      repeat (5) @(negedge clk);
      chk("exc_src_sticky", exc_src, 4'b1000);
      chk("exc_out_sticky", exception, 1);

      // Exceptions do not disturb traffic
      en_mask  = 4'b1010;
      ack_mode = 1;
      repeat (20) @(posedge clk);
      drain();
      do_reset();
      @(negedge clk);
      chk("exc_rst_src", exc_src, 0);
      chk("exc_rst_out", exception, 0);

`ifdef STREAM_MERGE_RR_TIMEOUT_EN
      // Watchdog: sink never acks, word dropped after TO send cycles
      en_mask  = 4'b0010;
      ack_mode = 0;
      repeat (14) @(posedge clk);
      en_mask  = 4'b0001;
      repeat (2) @(negedge clk);
      chk("to_exception", exception, 1);
      ack_mode = 1;
      en_mask  = 4'b0011;
      repeat (20) @(posedge clk);
      drain();
      chk("to_exc_src", exc_src, 0);
`endif

      chk("sb_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/stream_merge_rr.md
Name: stream_merge_rr

Overview:
- Parametrised N-to-1 stream merger for the user_design top level.
- Replaces point-to-point wiring of one process to one physical output. Several Chips processes can now share one output stream (e.g. rs232_tx) through round-robin arbitration using the standard stb/ack handshake.
- Also aggregates per-process exception lines into a registered, sticky exception with a source vector.

Parameters:
- N, 4, number of input channels (1..16).
- WIDTH, 32, data width of every stream.
- CW, 2, channel-index width; must equal max(1, ceil(log2 N)).
- TIMEOUT, 1024, output-ack watchdog limit in cycles; used only with the optional feature (>=2).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-low reset.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_stb  in  N  per-channel strobe; source holds data and stb until acked.
- in_ack  out  N  per-channel ack, registered, one-hot or zero.
- out_data  out  WIDTH  merged data, registered.
- out_chan  out  CW  index of the channel that supplied out_data.
- out_stb  out  1  merged strobe, registered.
- out_ack  in  1  sink ack.
- exc_in  in  N  per-process exception lines.
- exception  out  1  registered OR of all sticky exception bits.
- exc_src  out  N  sticky per-channel exception bits.

Behaviour:
- Transfer rule: a word moves on any cycle where stb and ack are both high. Only then.
- Reset (rst=0 at a clock edge):
  - in_ack=0, out_stb=0, out_data=0, out_chan=0, exception=0, exc_src=0.
  - last_grant=N-1, so channel 0 has first priority.
  - FSM goes to IDLE.
  - Reset mid-operation abandons any held word. No ack is issued for it.
- FSM states:
  - IDLE:
    - If any in_stb is high, select g as the first requesting channel in the order last_grant+1, last_grant+2, ... modulo N.
    - Register in_ack[g]=1 and go to ACCEPT.
    - Otherwise stay in IDLE.
  - ACCEPT:
    - in_ack[g] is high for exactly this one cycle, so the source's stb is necessarily high.
    - Capture in_data[g] into out_data and g into out_chan.
    - Drive in_ack to 0, set out_stb=1, go to SEND.
  - SEND:
    - Hold out_stb, out_data and out_chan stable.
    - On out_ack=1: out_stb=0, last_grant=g, go to IDLE.
- Latency and throughput:
  - 2 cycles from stb seen in IDLE to out_stb high.
  - Minimum 3 cycles per word with out_ack tied high.
- Fairness:
  - A channel that keeps stb high waits at most N-1 grants of other channels.
  - Simultaneous requests resolve purely by rotating priority.
- Strobe withdrawal: a strobe that drops while the channel is not granted is ignored (legal).
- Single channel (N=1): arbitration is trivial, out_chan=0 always, same timing.
- Exceptions:
  - exc_src[i] sets on any cycle where exc_in[i]=1 and clears only on reset.
  - exception = |exc_src, registered, so it appears one cycle after exc_src.
  - Exceptions do not stall or alter data flow.

Optional Feature:
- Macro: STREAM_MERGE_RR_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to SEND and increments each cycle in SEND without out_ack.
  - When it reaches TIMEOUT-1 without ack, the word is dropped: out_stb=0, go to IDLE, last_grant=g.
  - A sticky internal timeout flag is set; exception includes it, i.e. exception = |exc_src | timeout_flag.
  - The flag clears only on reset.
  - out_ack arriving in the same cycle as expiry counts as a normal transfer; no drop, no flag.
- Undefined: SEND waits indefinitely, TIMEOUT is ignored, no counter logic is generated.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all stb high → in_ack=0, out_stb=0, exception=0 throughout. After release, channel 0 is granted first.
- Single word: N=4, only in_stb[2]=1, in_data ch2=32'hDEADBEEF, out_ack=1 → in_ack[2] high for 1 cycle; out_stb 2 cycles after stb is sampled; out_data=DEADBEEF, out_chan=2.
- Round robin: all four stb held high, distinct data, out_ack=1 → out_chan sequence 0,1,2,3,0,1, with one word every 3 cycles.
- Backpressure: out_ack=0 for 20 cycles then 1 → out_data and out_chan stable, out_stb high throughout, no new in_ack during the stall.
- Exceptions: pulse exc_in[3] for one cycle → exc_src=4'b1000 next cycle, exception=1 one cycle later; both stay set until reset.
- Timeout (macro defined, TIMEOUT=8): out_ack held 0 → out_stb drops after 8 SEND cycles, exception=1. The next request is granted normally with rotated priority.
